vsqrt_lane: RTL and testbench

Parametrised vector integer square-root unit for the vector coprocessor, the native-RTL successor to the IP-core-based sqrt helper. It processes a vector of VLR elements: each operand comes either from a streamed vector register port or from a broadcast scalar. Results stream out through a fully pipelined, one-root-bit-per-stage datapath with output backpressure. Each result carries its element's mask bit and a remainder, and the unit reports busy/done to the vector issue logic.

---
 rtl/vsqrt_lane.sv | 226 ++++++++++++++++++++++
 tb/tb_vsqrt_lane.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vsqrt_lane.sv
// vsqrt_lane: vector integer square-root lane.
//
// Processes one vector of up to MVL elements per operation. Every element is
// taken either from the streamed operand port or from a broadcast scalar, run
// through a restoring square-root pipeline that resolves one root bit per
// stage, and delivered with its mask bit and remainder.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   start           begin an operation (sampled only while busy=0)
//   cont_esc        operand source: 2'b10 = broadcast op_esc, else streamed
//   op_esc          broadcast scalar {valid, data}, captured on start
//   mask            per-element mask, captured on start
//   vlr             vector length, captured on start, clamped to MVL
//   arg_valid/arg_data/arg_ready   streamed operand input
//   out_valid/out_ready            result handshake
//   out_mask/out_data/out_rem      element mask bit, floor(sqrt(x)), x - root^2
//   busy            operation in progress
//   done            one-cycle pulse after the final result handshake
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds valid and its payload steady until the
// transfer; ready may depend combinationally on the consumer's state. Here
// arg_ready and the whole pipeline advance depend on out_ready, while
// out_valid and its payload never depend on out_ready.

module vsqrt_lane #(
  parameter int DATA_WIDTH = 32,
  parameter int MVL        = 32,
  localparam int VLW       = $clog2(MVL) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            cont_esc,
  input  logic [DATA_WIDTH:0]   op_esc,
  input  logic [MVL-1:0]        mask,
  input  logic [VLW-1:0]        vlr,
  input  logic                  arg_valid,
  input  logic [DATA_WIDTH-1:0] arg_data,
  output logic                  arg_ready,
  output logic                  out_valid,
  output logic                  out_mask,
  output logic [DATA_WIDTH/2-1:0] out_data,
  output logic [DATA_WIDTH/2:0]   out_rem,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int S    = DATA_WIDTH / 2;
  localparam int IDXW = (MVL > 1) ? $clog2(MVL) : 1;

  // Per-stage payload. rad is the radicand still to be consumed, kept
  // left-aligned so its top two bits are always the next pair to bring down.
  typedef struct packed {
    logic [S:0]            rem;
    logic [S-1:0]          root;
    logic [DATA_WIDTH-1:0] rad;
  } stage_t;

  // One restoring step: bring down two radicand bits, try subtracting
  // (4*root + 1); keep the difference and set the new root bit if it fits.
  function automatic stage_t sqrt_step(input stage_t cur);
    stage_t     nxt;
    logic [S+2:0] acc;
    logic [S+2:0] trial;
    logic         ge;
    acc      = {cur.rem, cur.rad[DATA_WIDTH-1 -: 2]};
    trial    = {1'b0, cur.root, 2'b01};
    ge       = (acc >= trial);
    nxt.rem  = ge ? (S+1)'(acc - trial) : (S+1)'(acc);
    nxt.root = S'({cur.root, ge});
    nxt.rad  = DATA_WIDTH'({cur.rad, 2'b00});
    return nxt;
  endfunction

  // ---------------------------------------------------------------------
  // Operation control registers
  // ---------------------------------------------------------------------
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [VLW-1:0]        vlr_q, vlr_d;
  logic [VLW-1:0]        issued_q, issued_d;
  logic [VLW-1:0]        retired_q, retired_d;
  logic [MVL-1:0]        mask_q, mask_d;
  logic [1:0]            cont_esc_q, cont_esc_d;
  logic [DATA_WIDTH:0]   op_esc_q, op_esc_d;

  // ---------------------------------------------------------------------
  // Pipeline registers. Entry 0 holds the freshly issued operand; entry
  // k+1 holds the result of resolving root bit S-1-k. Entry S is the output.
  // ---------------------------------------------------------------------
  logic [S:0] vld_q, vld_d;
  logic [S:0] msk_q, msk_d;
  stage_t     st_q [S+1];
  stage_t     st_d [S+1];

  logic                  adv;
  logic                  bcast;
  logic                  can_issue;
  logic                  issue_fire;
  logic                  issue_mask;
  logic [DATA_WIDTH-1:0] issue_data;
  logic                  out_fire;
  logic [VLW-1:0]        vlr_clamped;

  assign out_valid = vld_q[S];
  assign out_mask  = msk_q[S];
  assign out_data  = st_q[S].root;
  assign out_rem   = st_q[S].rem;
  assign busy      = busy_q;
  assign done      = done_q;

  // Every stage moves together; a stalled output freezes the whole pipe.
  assign adv      = ~out_valid | out_ready;
  assign out_fire = out_valid & out_ready;

  assign vlr_clamped = (vlr > VLW'(MVL)) ? VLW'(MVL) : vlr;
  assign bcast       = (cont_esc_q == 2'b10);
  assign can_issue   = busy_q & adv & (issued_q < vlr_q);
  assign arg_ready   = can_issue & ~bcast;
  // A broadcast with its valid bit clear never issues; the operation then
  // stays busy until reset.
  assign issue_fire  = can_issue & (bcast ? op_esc_q[DATA_WIDTH] : arg_valid);
  assign issue_data  = bcast ? op_esc_q[DATA_WIDTH-1:0] : arg_data;
  assign issue_mask  = mask_q[issued_q[IDXW-1:0]];

  // ---------------------------------------------------------------------
  // Control next-state
  // ---------------------------------------------------------------------
  always_comb begin
    busy_d     = busy_q;
    done_d     = 1'b0;
    vlr_d      = vlr_q;
    issued_d   = issued_q;
    retired_d  = retired_q;
    mask_d     = mask_q;
    cont_esc_d = cont_esc_q;
    op_esc_d   = op_esc_q;

    if (!busy_q) begin
      if (start) begin
        vlr_d      = vlr_clamped;
        mask_d     = mask;
        cont_esc_d = cont_esc;
        op_esc_d   = op_esc;
        issued_d   = '0;
        retired_d  = '0;
        // An empty vector completes immediately without ever going busy.
        busy_d     = (vlr_clamped != '0);
        done_d     = (vlr_clamped == '0);
      end
    end else begin
      if (issue_fire) begin
        issued_d = issued_q + VLW'(1);
      end
      if (out_fire) begin
        retired_d = retired_q + VLW'(1);
        if (retired_d == vlr_q) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Pipeline next-state
  // ---------------------------------------------------------------------
  always_comb begin
    vld_d = vld_q;
    msk_d = msk_q;
    for (int k = 0; k <= S; k++) begin
      st_d[k] = st_q[k];
    end

    if (adv) begin
      vld_d[0]    = issue_fire;
      msk_d[0]    = issue_mask;
      st_d[0]     = '0;
      st_d[0].rad = issue_data;
      for (int k = 0; k < S; k++) begin
        vld_d[k+1] = vld_q[k];
        msk_d[k+1] = msk_q[k];
        st_d[k+1]  = sqrt_step(st_q[k]);
      end
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      vlr_q      <= '0;
      issued_q   <= '0;
      retired_q  <= '0;
      mask_q     <= '0;
      cont_esc_q <= '0;
      op_esc_q   <= '0;
      vld_q      <= '0;
      msk_q      <= '0;
      for (int k = 0; k <= S; k++) begin
        st_q[k] <= '0;
      end
    end else begin
      busy_q     <= busy_d;
      done_q     <= done_d;
      vlr_q      <= vlr_d;
      issued_q   <= issued_d;
      retired_q  <= retired_d;
      mask_q     <= mask_d;
      cont_esc_q <= cont_esc_d;
      op_esc_q   <= op_esc_d;
      vld_q      <= vld_d;
      msk_q      <= msk_d;
      for (int k = 0; k <= S; k++) begin
        st_q[k] <= st_d[k];
      end
    end
  end

endmodule

// File: tb/tb_vsqrt_lane.sv
// tb_vsqrt_lane: directed + randomized bench for vsqrt_lane.
// Expected results come from an integer square-root model (floor of a real
// square root, corrected with exact integer arithmetic) kept in a scoreboard
// queue in issue order; a negedge monitor compares the queue head against
// the DUT outputs every cycle out_valid is high.

module tb_vsqrt_lane;
  localparam int DW  = 32;
  localparam int MVL = 32;
  localparam int VLW = $clog2(MVL) + 1;
  localparam int S   = DW / 2;
  localparam int EW  = 1 + (DW/2 + 1) + DW/2; // {mask, rem, root}

  logic              clk;
  logic              rst;
  logic              start;
  logic [1:0]        cont_esc;
  logic [DW:0]       op_esc;
  logic [MVL-1:0]    mask;
  logic [VLW-1:0]    vlr;
  logic              arg_valid;
  logic [DW-1:0]     arg_data;
  logic              arg_ready;
  logic              out_valid;
  logic              out_mask;
  logic [DW/2-1:0]   out_data;
  logic [DW/2:0]     out_rem;
  logic              out_ready;
  logic              busy;
  logic              done;

  int cmp_cnt  = 0;
  int fail_cnt = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int res_cnt  = 0;
  int accept_cyc      = -1;
  int first_valid_cyc = -1;
  bit bcast_chk = 0;
  int rdy_mode  = 0;

  logic [EW-1:0]  exp_q[$];
  logic [DW-1:0]  src_q[$];
  logic [MVL-1:0] cur_mask;

  vsqrt_lane #(.DATA_WIDTH(DW), .MVL(MVL)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cont_esc  (cont_esc),
    .op_esc    (op_esc),
    .mask      (mask),
    .vlr       (vlr),
    .arg_valid (arg_valid),
    .arg_data  (arg_data),
    .arg_ready (arg_ready),
    .out_valid (out_valid),
    .out_mask  (out_mask),
    .out_data  (out_data),
    .out_rem   (out_rem),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] model(input logic m, input logic [DW-1:0] x);
    longint unsigned xv;
    longint unsigned r;
    xv = 64'(x);
    r  = 64'($rtoi($sqrt(real'(xv))));
    while (r * r > xv) r = r - 1;
    while ((r + 1) * (r + 1) <= xv) r = r + 1;
    model = {m, (DW/2+1)'(xv - r * r), (DW/2)'(r)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    cmp_cnt++;
    assert (obs === exp_v) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] ce, input logic [DW:0] oe,
                          input logic [MVL-1:0] m, input logic [VLW-1:0] len);
    start    = 1'b1;
    cont_esc = ce;
    op_esc   = oe;
    mask     = m;
    vlr      = len;
    cur_mask = m;
    tick();
    start = 1'b0;
  endtask

  // Offers src_q operands until max_acc are accepted or done is seen.
  // start_at >= 0 pulses a (to-be-ignored) start while element start_at is offered.
  task automatic run_stream(input int max_acc, input int start_at, input bit gaps,
                            output int n_acc, output bit saw_done);
    int budget;
    budget   = 3000;
    n_acc    = 0;
    saw_done = 1'b0;
    while (!saw_done && n_acc < max_acc && budget > 0) begin
      arg_valid = (src_q.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
      arg_data  = (src_q.size() > 0) ? src_q[0] : '0;
      if (n_acc == start_at) begin
        start    = 1'b1;
        cont_esc = 2'b10;
        op_esc   = {1'b1, 32'd49};
        vlr      = VLW'(2);
        mask     = '0;
      end
      #1;
      if (arg_valid && arg_ready) begin
        if (accept_cyc < 0) accept_cyc = cyc + 1;
        exp_q.push_back(model(cur_mask[n_acc], src_q[0]));
        void'(src_q.pop_front());
        n_acc++;
      end
      tick();
      start = 1'b0;
      budget--;
      if (done) saw_done = 1'b1;
    end
    arg_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit saw_done);
    saw_done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done) begin
        saw_done = 1'b1;
        break;
      end
    end
  endtask

  // out_ready pattern: 0 = always ready, 1 = one on / two off, 2 = random
  initial begin
    int phase;
    phase     = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: begin
          out_ready = (phase == 0);
          phase     = (phase + 1) % 3;
        end
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst) begin
      if (out_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", out_valid, 1'b0);
        end else begin
          e = exp_q[0];
          check("out_data", out_data, e[DW/2-1:0]);
          check("out_rem",  out_rem,  e[DW-1+1:DW/2]);
          check("out_mask", out_mask, e[EW-1]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            res_cnt++;
          end
        end
        if (!out_ready) check("stall_arg_ready", arg_ready, 1'b0);
      end
      if (bcast_chk) check("bcast_arg_ready", arg_ready, 1'b0);
      if (done) done_cnt++;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    bit sd;
    int d0;
    int r0;
    logic [DW-1:0] v;

    rst = 1'b1; start = 1'b0; cont_esc = 2'b00; op_esc = '0; mask = '0;
    vlr = '0; arg_valid = 1'b0; arg_data = '0; cur_mask = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_arg_ready", arg_ready, 1'b0);
    check("rst_out_mask", out_mask, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_rem", out_rem, '0);
    tick();

    // streamed, vlr=5, boundary operands
    rdy_mode = 0; accept_cyc = -1; first_valid_cyc = -1; d0 = done_cnt; r0 = res_cnt;
    do_start(2'b01, '0, '1, VLW'(5));
    src_q.push_back(32'd0);
    src_q.push_back(32'd1);
    src_q.push_back(32'd2);
    src_q.push_back(32'd1000000);
    src_q.push_back(32'hFFFF_FFFF);
    run_stream(1000, -1, 1'b0, n, sd);
    check("t1_accepts", n, 5);
    check("t1_done_seen", sd, 1'b1);
    check("t1_busy_after", busy, 1'b0);
    check("t1_latency", first_valid_cyc - accept_cyc, S);
    tick();
    tick();
    check("t1_done_pulses", done_cnt - d0, 1);
    check("t1_results", res_cnt - r0, 5);
    check("t1_drained", exp_q.size(), 0);

    // broadcast 144, mask 0101
    r0 = res_cnt;
    bcast_chk = 1'b1;
    do_start(2'b10, {1'b1, 32'd144}, MVL'(4'b0101), VLW'(4));
    for (int i = 0; i < 4; i++) exp_q.push_back(model(cur_mask[i], 32'd144));
    wait_done(500, sd);
    bcast_chk = 1'b0;
    check("t2_done_seen", sd, 1'b1);
    check("t2_results", res_cnt - r0, 4);
    check("t2_drained", exp_q.size(), 0);
    tick();

    // backpressure 1-on/2-off, vlr=8 random
    rdy_mode = 1; r0 = res_cnt;
    do_start(2'b00, '0, '1, VLW'(8));
    for (int i = 0; i < 8; i++) src_q.push_back($urandom);
    run_stream(1000, -1, 1'b0, n, sd);
    check("t3_accepts", n, 8);
    check("t3_done_seen", sd, 1'b1);
    check("t3_results", res_cnt - r0, 8);
    check("t3_drained", exp_q.size(), 0);
    rdy_mode = 0;
    tick();

    // random gaps and random out_ready, mixed operand classes
    rdy_mode = 2; r0 = res_cnt;
    do_start(2'b11, '0, MVL'($urandom), VLW'(20));
    for (int i = 0; i < 20; i++) begin
      case (i % 4)
        0: begin v = DW'($urandom_range(0, 65535)); v = v * v; end
        1: v = 32'hFFFF_FFFF - DW'($urandom_range(0, 3));
        2: v = DW'($urandom_range(0, 15));
        default: v = $urandom;
      endcase
      src_q.push_back(v);
    end
    run_stream(1000, -1, 1'b1, n, sd);
    check("t4_accepts", n, 20);
    check("t4_done_seen", sd, 1'b1);
    check("t4_results", res_cnt - r0, 20);
    check("t4_drained", exp_q.size(), 0);
    rdy_mode = 0;
    tick();

    // vlr=0
    d0 = done_cnt;
    do_start(2'b00, '0, '1, VLW'(0));
    check("t5_busy", busy, 1'b0);
    check("t5_done", done, 1'b1);
    check("t5_arg_ready", arg_ready, 1'b0);
    tick();
    check("t5_done_drop", done, 1'b0);
    tick();
    check("t5_done_pulses", done_cnt - d0, 1);

    // vlr=40 clamps to MVL
    r0 = res_cnt;
    do_start(2'b00, '0, '1, VLW'(40));
    for (int i = 0; i < 40; i++) src_q.push_back($urandom);
    run_stream(1000, -1, 1'b0, n, sd);
    check("t6_accepts", n, MVL);
    check("t6_done_seen", sd, 1'b1);
    check("t6_results", res_cnt - r0, MVL);
    check("t6_leftover_src", src_q.size(), 40 - MVL);
    check("t6_drained", exp_q.size(), 0);
    src_q.delete();
    tick();

    // reset mid-operation after 10 accepts
    do_start(2'b00, '0, '1, VLW'(16));
    for (int i = 0; i < 16; i++) src_q.push_back($urandom);
    run_stream(10, -1, 1'b0, n, sd);
    check("t7_accepts_before_rst", n, 10);
    rst = 1'b1;
    tick();
    check("t7_busy", busy, 1'b0);
    check("t7_out_valid", out_valid, 1'b0);
    check("t7_done", done, 1'b0);
    check("t7_arg_ready", arg_ready, 1'b0);
    exp_q.delete();
    src_q.delete();
    rst = 1'b0;
    tick();
    r0 = res_cnt;
    do_start(2'b00, '0, '1, VLW'(2));
    src_q.push_back(32'd81);
    src_q.push_back(32'd99);
    run_stream(1000, -1, 1'b0, n, sd);
    check("t7_post_done_seen", sd, 1'b1);
    check("t7_post_results", res_cnt - r0, 2);
    check("t7_post_drained", exp_q.size(), 0);
    tick();

    // start while busy is ignored
    r0 = res_cnt;
    do_start(2'b00, '0, MVL'($urandom), VLW'(6));
    for (int i = 0; i < 6; i++) src_q.push_back($urandom);
    run_stream(1000, 3, 1'b0, n, sd);
    check("t8_accepts", n, 6);
    check("t8_done_seen", sd, 1'b1);
    check("t8_results", res_cnt - r0, 6);
    check("t8_drained", exp_q.size(), 0);
    tick();
    tick();
    check("t8_idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
